fpaddsub_round_arbiter: RTL and testbench
=========================================

Name: fpaddsub_round_arbiter

Overview:
- Shares one IEEE-754 single-precision rounding datapath among NREQ upstream add/sub normalise stages.
- Each requester presents a normalised result (sign, exponent, mantissa, round bit, sticky bit, rounding mode) on a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle into a 2-stage pipeline, and results leave tagged with the requester index.
- Per-requester sticky Inexact and Overflow flags are kept for status readout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TW, 2, tag width; TW equals ceil(log2(NREQ)).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- InValid  in  NREQ  request valid, one bit per requester.
- InReady  out  NREQ  grant/accept, one bit per requester.
- InSgn  in  NREQ  sign per requester.
- InNormE  in  8*NREQ  normalised exponent, slice i = [8i+7:8i].
- InNormM  in  23*NREQ  normalised mantissa.
- InR  in  NREQ  round bit.
- InS  in  NREQ  sticky bit.
- InMode  in  2*NREQ  rounding mode (00 nearest-even, 01 +inf, 10 toward zero, 11 -inf).
- OutValid  out  1  result valid.
- OutReady  in  1  downstream accept.
- OutZ  out  32  rounded result.
- OutTag  out  TW  index of originating requester.
- OutInexact  out  1  R|S of this result.
- OutOverflow  out  1  rounding carried exponent to 8'hFF.
- ClrFlags  in  1  one-cycle pulse, clears sticky flags.
- FlagInexact  out  NREQ  sticky inexact per requester.
- FlagOverflow  out  NREQ  sticky overflow per requester.

Behaviour:
- Reset (async assert, sync release):
  - OutValid=0, OutZ=0, OutTag=0, OutInexact=0, OutOverflow=0.
  - Both pipeline valid bits 0; Flag* = 0; round-robin pointer = 0.
  - InReady=0 while RSTn low.
- Pipeline: S1 (captured operands + tag), then S2 (rounded result = output register). Occupancy states: EMPTY (S1 and S2 empty), HALF (one stage valid), FULL (both valid).
- Advance rules:
  - adv2 = ~S2.v | OutReady.
  - S1 moves to S2 when S1.v & adv2.
  - accept = ~S1.v | (S1.v & adv2).
- Arbitration (combinational, evaluated when accept=1):
  - Pick the first InValid[i] scanning from the pointer upward, with wrap.
  - InReady[i]=1 for that single index only; all others 0.
  - On a transfer the pointer becomes i+1 mod NREQ.
  - With no request, or accept=0, all InReady=0 and the pointer holds.
- Handshake: a transfer occurs when InValid[i]&InReady[i]. Requesters must hold data stable until accepted. InReady never depends on OutValid combinationally except through adv2.
- Latency: accept in cycle N gives OutValid in N+2 with no stall. Throughput is 1/cycle with OutReady held high.
- Round datapath (between S1 and S2):
  - RoundUp = (mode00 & R & (S|M[0])) | (mode01 & (R|S) & ~Sgn) | (mode11 & (R|S) & Sgn). Mode 10 never rounds up.
  - RM24 = M+1 (24-bit). RoundOF = RoundUp & RM24[23].
  - Mant = RoundUp ? RM24[22:0] : M. Exp = (E + RoundOF) mod 256.
  - OutZ = {Sgn, Exp, Mant}. OutInexact = R|S. OutOverflow = RoundOF & (E==8'hFE).
  - E==8'hFF with RoundOF wraps to 8'h00 and does not set overflow. Upstream never sends E=FF; this is documented, not checked.
- Output holds stable while OutValid & ~OutReady.
- Flags: when a result is loaded into S2 with tag t:
  - FlagInexact[t] |= OutInexact.
  - FlagOverflow[t] |= OutOverflow.
  - ClrFlags clears all bits. A set in the same cycle as ClrFlags wins for its bit.
- Mid-operation reset: in-flight results are discarded, with no partial output.

Test Plan:
- Single request, requester 0: Sgn=0, E=7F, M=7FFFFF, R=1, S=0, mode 00 → OutZ=0x40000000, OutTag=0, OutInexact=1, OutValid exactly 2 cycles after accept.
- Tie to even, requester 2: E=7F, M=000002, R=1, S=0, mode 00 → OutZ=0x3F800002, no roundup. Then mode 10, Sgn=1, E=80, M=400000, R=1, S=1 → OutZ=0xC0400000, FlagInexact[2]=1.
- Overflow, requester 1: Sgn=0, E=FE, M=7FFFFF, R=1, mode 01 → OutZ=0x7F800000, OutOverflow=1, FlagOverflow[1]=1. ClrFlags pulse → flags 0. Set and clear in the same cycle → bit stays 1.
- Fairness: all 4 InValid held high, OutReady=1 → grants 0,1,2,3,0 on consecutive cycles, tags out in the same order, 1 result/cycle.
- Backpressure: OutReady=0 for 5 cycles with continuous requests → exactly 2 accepts, then InReady=0. OutZ/OutTag stable. Release → no loss or duplication, order preserved.
- Async reset asserted mid-stream with FULL pipeline → OutValid=0 immediately, InReady=0, flags 0. After release the first grant goes to requester 0.

Source files
------------

// File: rtl/fpaddsub_round_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single-precision rounding stage among NREQ
// normalise stages; 2-stage pipeline (capture, round) with per-requester sticky flags.
module fpaddsub_round_arbiter #(
  parameter int NREQ = 4,
  parameter int TW   = 2
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [NREQ-1:0]      InValid,
  output logic [NREQ-1:0]      InReady,
  input  logic [NREQ-1:0]      InSgn,
  input  logic [8*NREQ-1:0]    InNormE,
  input  logic [23*NREQ-1:0]   InNormM,
  input  logic [NREQ-1:0]      InR,
  input  logic [NREQ-1:0]      InS,
  input  logic [2*NREQ-1:0]    InMode,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [31:0]          OutZ,
  output logic [TW-1:0]        OutTag,
  output logic                 OutInexact,
  output logic                 OutOverflow,
  input  logic                 ClrFlags,
  output logic [NREQ-1:0]      FlagInexact,
  output logic [NREQ-1:0]      FlagOverflow
);

  localparam logic [TW:0]   NREQ_W   = (TW+1)'(NREQ);
  localparam logic [TW-1:0] LAST_IDX = TW'(NREQ-1);

  logic            r_s1_v;
  logic            r_s1_sgn;
  logic [7:0]      r_s1_e;
  logic [22:0]     r_s1_m;
  logic            r_s1_r;
  logic            r_s1_s;
  logic [1:0]      r_s1_mode;
  logic [TW-1:0]   r_s1_tag;
  logic [TW-1:0]   r_ptr;
  logic            r_s2_v;
  logic [31:0]     r_out_z;
  logic [TW-1:0]   r_out_tag;
  logic            r_out_inx;
  logic            r_out_ovf;
  logic [NREQ-1:0] r_flag_inx;
  logic [NREQ-1:0] r_flag_ovf;

  logic            w_adv2;
  logic            w_s1_go;
  logic            w_accept;
  logic            w_found;
  logic            w_xfer;
  logic [TW-1:0]   w_idx;
  logic [TW:0]     w_sum;
  logic [TW-1:0]   w_cand;
  logic [TW-1:0]   w_ptr_nxt;
  logic            w_sel_sgn;
  logic [7:0]      w_sel_e;
  logic [22:0]     w_sel_m;
  logic            w_sel_r;
  logic            w_sel_s;
  logic [1:0]      w_sel_mode;
  logic            w_round_up;
  logic [23:0]     w_rm24;
  logic            w_round_of;
  logic [22:0]     w_mant;
  logic [7:0]      w_exp;
  logic            w_inexact;
  logic            w_ovf;
  logic [NREQ-1:0] w_set_inx;
  logic [NREQ-1:0] w_set_ovf;

  assign w_adv2    = ~r_s2_v | OutReady;
  assign w_s1_go   = r_s1_v & w_adv2;
  assign w_accept  = ~r_s1_v | w_s1_go;
  assign w_xfer    = w_accept & w_found & RSTn;
  assign w_ptr_nxt = (w_idx == LAST_IDX) ? {TW{1'b0}} : w_idx + TW'(1);

  // Scan from the pointer with wrap; the descending loop leaves the nearest requester in w_idx.
  always_comb begin
    w_found = 1'b0;
    w_idx   = {TW{1'b0}};
    w_sum   = {(TW+1){1'b0}};
    w_cand  = {TW{1'b0}};
    for (int k = NREQ-1; k >= 0; k--) begin
      w_sum   = {1'b0, r_ptr} + (TW+1)'(k);
      w_cand  = (w_sum >= NREQ_W) ? TW'(w_sum - NREQ_W) : w_sum[TW-1:0];
      w_found = w_found | InValid[w_cand];
      w_idx   = InValid[w_cand] ? w_cand : w_idx;
    end
  end

  // One-hot grant, also used as the AND-OR select for the operand mux.
  always_comb begin
    InReady    = {NREQ{1'b0}};
    w_sel_sgn  = 1'b0;
    w_sel_e    = 8'd0;
    w_sel_m    = 23'd0;
    w_sel_r    = 1'b0;
    w_sel_s    = 1'b0;
    w_sel_mode = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      InReady[i] = w_xfer & (w_idx == TW'(i));
      w_sel_sgn  = w_sel_sgn | (InReady[i] & InSgn[i]);
      w_sel_e    = w_sel_e | ({8{InReady[i]}} & InNormE[8*i +: 8]);
      w_sel_m    = w_sel_m | ({23{InReady[i]}} & InNormM[23*i +: 23]);
      w_sel_r    = w_sel_r | (InReady[i] & InR[i]);
      w_sel_s    = w_sel_s | (InReady[i] & InS[i]);
      w_sel_mode = w_sel_mode | ({2{InReady[i]}} & InMode[2*i +: 2]);
    end
  end

  // Rounding datapath; an exponent of FF with carry wraps to 00 without flagging overflow.
  always_comb begin
    case (r_s1_mode)
      2'b00:   w_round_up = r_s1_r & (r_s1_s | r_s1_m[0]);
      2'b01:   w_round_up = (r_s1_r | r_s1_s) & ~r_s1_sgn;
      2'b11:   w_round_up = (r_s1_r | r_s1_s) & r_s1_sgn;
      default: w_round_up = 1'b0;
    endcase
    w_rm24     = {1'b0, r_s1_m} + 24'd1;
    w_round_of = w_round_up & w_rm24[23];
    w_mant     = w_round_up ? w_rm24[22:0] : r_s1_m;
    w_exp      = r_s1_e + {7'd0, w_round_of};
    w_inexact  = r_s1_r | r_s1_s;
    w_ovf      = w_round_of & (r_s1_e == 8'hFE);
  end

  // Flag set vectors for the result entering S2.
  always_comb begin
    w_set_inx = {NREQ{1'b0}};
    w_set_ovf = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_set_inx[i] = w_s1_go & w_inexact & (r_s1_tag == TW'(i));
      w_set_ovf[i] = w_s1_go & w_ovf & (r_s1_tag == TW'(i));
    end
  end

  // S1 capture stage and round-robin pointer.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s1_v    <= 1'b0;
      r_s1_sgn  <= 1'b0;
      r_s1_e    <= 8'd0;
      r_s1_m    <= 23'd0;
      r_s1_r    <= 1'b0;
      r_s1_s    <= 1'b0;
      r_s1_mode <= 2'd0;
      r_s1_tag  <= {TW{1'b0}};
      r_ptr     <= {TW{1'b0}};
    end else begin
      if (w_accept) begin
        r_s1_v <= w_xfer;
      end
      if (w_xfer) begin
        r_s1_sgn  <= w_sel_sgn;
        r_s1_e    <= w_sel_e;
        r_s1_m    <= w_sel_m;
        r_s1_r    <= w_sel_r;
        r_s1_s    <= w_sel_s;
        r_s1_mode <= w_sel_mode;
        r_s1_tag  <= w_idx;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  // S2 output register; holds while stalled.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s2_v    <= 1'b0;
      r_out_z   <= 32'd0;
      r_out_tag <= {TW{1'b0}};
      r_out_inx <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (w_s1_go) begin
      r_s2_v    <= 1'b1;
      r_out_z   <= {r_s1_sgn, w_exp, w_mant};
      r_out_tag <= r_s1_tag;
      r_out_inx <= w_inexact;
      r_out_ovf <= w_ovf;
    end else if (w_adv2) begin
      r_s2_v <= 1'b0;
    end
  end

  // Sticky flags: a set in the clearing cycle survives for its bit.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_flag_inx <= {NREQ{1'b0}};
      r_flag_ovf <= {NREQ{1'b0}};
    end else begin
      r_flag_inx <= (ClrFlags ? {NREQ{1'b0}} : r_flag_inx) | w_set_inx;
      r_flag_ovf <= (ClrFlags ? {NREQ{1'b0}} : r_flag_ovf) | w_set_ovf;
    end
  end

  assign OutValid     = r_s2_v;
  assign OutZ         = r_out_z;
  assign OutTag       = r_out_tag;
  assign OutInexact   = r_out_inx;
  assign OutOverflow  = r_out_ovf;
  assign FlagInexact  = r_flag_inx;
  assign FlagOverflow = r_flag_ovf;

endmodule

// File: tb/tb_fpaddsub_round_arbiter.sv
// Directed bench for fpaddsub_round_arbiter: rounding vector table, flag sequences,
// backpressure, async reset with a full pipeline, and round-robin fairness.
module tb_fpaddsub_round_arbiter;
  localparam int NREQ = 4;
  localparam int TW   = 2;

  logic              CLK;
  logic              RSTn;
  logic [NREQ-1:0]   InValid;
  logic [NREQ-1:0]   InReady;
  logic [NREQ-1:0]   InSgn;
  logic [8*NREQ-1:0] InNormE;
  logic [23*NREQ-1:0] InNormM;
  logic [NREQ-1:0]   InR;
  logic [NREQ-1:0]   InS;
  logic [2*NREQ-1:0] InMode;
  logic              OutValid;
  logic              OutReady;
  logic [31:0]       OutZ;
  logic [TW-1:0]     OutTag;
  logic              OutInexact;
  logic              OutOverflow;
  logic              ClrFlags;
  logic [NREQ-1:0]   FlagInexact;
  logic [NREQ-1:0]   FlagOverflow;

  int n_chk;
  int n_err;
  int n_acc;

  typedef struct {
    int          req;
    logic        sgn;
    logic [7:0]  e;
    logic [22:0] m;
    logic        r;
    logic        s;
    logic [1:0]  mode;
    logic [31:0] z;
    logic        inx;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  fpaddsub_round_arbiter #(.NREQ(NREQ), .TW(TW)) dut (
    .CLK(CLK), .RSTn(RSTn), .InValid(InValid), .InReady(InReady), .InSgn(InSgn),
    .InNormE(InNormE), .InNormM(InNormM), .InR(InR), .InS(InS), .InMode(InMode),
    .OutValid(OutValid), .OutReady(OutReady), .OutZ(OutZ), .OutTag(OutTag),
    .OutInexact(OutInexact), .OutOverflow(OutOverflow), .ClrFlags(ClrFlags),
    .FlagInexact(FlagInexact), .FlagOverflow(FlagOverflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] oh(input int g);
    logic [31:0] v;
    v = 32'd0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // stream data for requester t: mode 10, S=1 -> never rounds, always inexact
  function automatic logic [31:0] sz(input int t);
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'h10 + 8'(t);
    m = 23'h000100 + 23'(t);
    return {1'b0, e, m};
  endfunction

  task automatic set_req(input int i, input logic sgn, input logic [7:0] e, input logic [22:0] m,
                         input logic r, input logic s, input logic [1:0] md);
    InSgn[i]          = sgn;
    InNormE[8*i +: 8]  = e;
    InNormM[23*i +: 23] = m;
    InR[i]            = r;
    InS[i]            = s;
    InMode[2*i +: 2]  = md;
  endtask

  task automatic drive_all();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b0, 8'h10 + 8'(i), 23'h000100 + 23'(i), 1'b0, 1'b1, 2'b10);
    end
  endtask

  task automatic apply_vec(input vec_t v, input logic clr_at_load);
    @(negedge CLK);
    InSgn = '0; InNormE = '0; InNormM = '0; InR = '0; InS = '0; InMode = '0;
    set_req(v.req, v.sgn, v.e, v.m, v.r, v.s, v.mode);
    InValid = '0;
    InValid[v.req] = 1'b1;
    OutReady = 1'b1;
    #1;
    chk("grant", 32'(InReady), oh(v.req));
    @(negedge CLK);
    InValid = '0;
    ClrFlags = clr_at_load;
    #1;
    chk("lat_n1_novalid", 32'(OutValid), 32'd0);
    @(negedge CLK);
    ClrFlags = 1'b0;
    #1;
    chk("lat_n2_valid", 32'(OutValid), 32'd1);
    chk("outz", OutZ, v.z);
    chk("outtag", 32'(OutTag), 32'(v.req));
    chk("outinexact", 32'(OutInexact), 32'(v.inx));
    chk("outoverflow", 32'(OutOverflow), 32'(v.ovf));
  endtask

  int d_ordy  [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
  int d_grant [9] = '{2, 3, -1, -1, -1, 0, 1, 2, 3};
  int d_tag   [9] = '{-1, -1, 2, 2, 2, 2, 3, 0, 1};

  initial begin
    n_chk = 0; n_err = 0; n_acc = 0;
    RSTn = 1'b1; InValid = '0; OutReady = 1'b0; ClrFlags = 1'b0;
    InSgn = '0; InNormE = '0; InNormM = '0; InR = '0; InS = '0; InMode = '0;

    #1 RSTn = 1'b0;
    drive_all();
    InValid = '1;
    OutReady = 1'b1;
    #1;
    chk("rst_inready", 32'(InReady), 32'd0);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_outz", OutZ, 32'd0);
    chk("rst_outtag", 32'(OutTag), 32'd0);
    chk("rst_outinexact", 32'(OutInexact), 32'd0);
    chk("rst_outoverflow", 32'(OutOverflow), 32'd0);
    chk("rst_flaginx", 32'(FlagInexact), 32'd0);
    chk("rst_flagovf", 32'(FlagOverflow), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_inready_held", 32'(InReady), 32'd0);
    chk("rst_outvalid_held", 32'(OutValid), 32'd0);
    @(negedge CLK);
    InValid = '0;
    RSTn = 1'b1;

    vecs[0] = '{0, 1'b0, 8'h7F, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 32'h40000000, 1'b1, 1'b0};
    vecs[1] = '{2, 1'b0, 8'h7F, 23'h000002, 1'b1, 1'b0, 2'b00, 32'h3F800002, 1'b1, 1'b0};
    vecs[2] = '{2, 1'b1, 8'h80, 23'h400000, 1'b1, 1'b1, 2'b10, 32'hC0400000, 1'b1, 1'b0};
    vecs[3] = '{1, 1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 2'b01, 32'h7F800000, 1'b1, 1'b1};
    vecs[4] = '{3, 1'b1, 8'h81, 23'h000001, 1'b0, 1'b1, 2'b11, 32'hC0800002, 1'b1, 1'b0};
    vecs[5] = '{0, 1'b0, 8'h01, 23'h123456, 1'b0, 1'b0, 2'b00, 32'h00923456, 1'b0, 1'b0};
    vecs[6] = '{3, 1'b0, 8'h10, 23'h000003, 1'b1, 1'b0, 2'b00, 32'h08000004, 1'b1, 1'b0};
    vecs[7] = '{1, 1'b1, 8'h20, 23'h0000FF, 1'b0, 1'b1, 2'b01, 32'h900000FF, 1'b1, 1'b0};
    vecs[8] = '{2, 1'b0, 8'hFF, 23'h7FFFFF, 1'b1, 1'b1, 2'b00, 32'h00000000, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      apply_vec(vecs[i], 1'b0);
    end
    chk("flaginx_after_table", 32'(FlagInexact), 32'h0000000F);
    chk("flagovf_after_table", 32'(FlagOverflow), 32'h00000002);

    // plain clear pulse
    @(negedge CLK);
    ClrFlags = 1'b1;
    @(negedge CLK);
    ClrFlags = 1'b0;
    #1;
    chk("clr_flaginx", 32'(FlagInexact), 32'd0);
    chk("clr_flagovf", 32'(FlagOverflow), 32'd0);

    // overflow set in the same cycle as a clear: the set bit survives
    apply_vec(vecs[3], 1'b1);
    chk("setclr_flagovf", 32'(FlagOverflow), 32'h00000002);
    chk("setclr_flaginx", 32'(FlagInexact), 32'h00000002);

    // backpressure: pointer is at 2, five stalled cycles then release
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        drive_all();
        InValid = '1;
      end
      OutReady = d_ordy[c][0];
      #1;
      chk("bp_grant", 32'(InReady), oh(d_grant[c]));
      if (c < 5 && (InValid & InReady) != '0) n_acc++;
      chk("bp_outvalid", 32'(OutValid), (d_tag[c] >= 0) ? 32'd1 : 32'd0);
      if (d_tag[c] >= 0) begin
        chk("bp_outtag", 32'(OutTag), 32'(d_tag[c]));
        chk("bp_outz", OutZ, sz(d_tag[c]));
      end
    end
    chk("bp_accepts", 32'(n_acc), 32'd2);

    // fill the pipeline, then reset asynchronously between edges
    @(negedge CLK);
    OutReady = 1'b0;
    #1;
    chk("full_inready", 32'(InReady), 32'd0);
    chk("full_outtag", 32'(OutTag), 32'd2);
    chk("full_flaginx", 32'(FlagInexact), 32'h0000000F);
    #2 RSTn = 1'b0;
    #1;
    chk("midrst_outvalid", 32'(OutValid), 32'd0);
    chk("midrst_inready", 32'(InReady), 32'd0);
    chk("midrst_outz", OutZ, 32'd0);
    chk("midrst_flaginx", 32'(FlagInexact), 32'd0);
    chk("midrst_flagovf", 32'(FlagOverflow), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    InValid = '0;
    RSTn = 1'b1;

    // fairness from a fresh pointer: grants 0,1,2,3,0,... and results one per cycle
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        InValid = '1;
      end
      OutReady = 1'b1;
      #1;
      chk("rr_grant", 32'(InReady), oh(c % 4));
      chk("rr_outvalid", 32'(OutValid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        chk("rr_outtag", 32'(OutTag), 32'((c - 2) % 4));
        chk("rr_outz", OutZ, sz((c - 2) % 4));
        chk("rr_outinexact", 32'(OutInexact), 32'd1);
      end
    end
    @(negedge CLK);
    InValid = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
